// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension sequencer: op codes, FSM states and
// result-cache classes.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIX, ST_RESP, ST_DRAIN
  } md_state_e;

  typedef enum logic [2:0] {
    CC_SDIV, CC_UDIV, CC_MULH, CC_MULHSU, CC_MULHU
  } md_class_e;

  // MUL computes with unsigned magnitudes, so its entry is a MULHU product.
  function automatic md_class_e op_class(input logic [2:0] op);
    case (op)
      MD_DIV, MD_REM:   return CC_SDIV;
      MD_DIVU, MD_REMU: return CC_UDIV;
      MD_MULH:          return CC_MULH;
      MD_MULHSU:        return CC_MULHSU;
      default:          return CC_MULHU;
    endcase
  endfunction

  function automatic logic op_takes_hi(input logic [2:0] op);
    return !(op == MD_MUL || op == MD_DIV || op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling around the unsigned engine: operand magnitudes
// on the way in, 2*XLEN result correction on the way out.
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              neg_a,
  input  logic              neg_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  input  logic              fix_div,
  input  logic              fix_sa,
  input  logic              fix_sb,
  input  logic [2*XLEN-1:0] raw,
  output logic [2*XLEN-1:0] fixed
);

  logic [XLEN-1:0] quo, rem;

  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  // Divide: quotient takes the xor of signs, remainder follows the dividend.
  always_comb begin
    quo   = raw[XLEN-1:0];
    rem   = raw[2*XLEN-1:XLEN];
    fixed = raw;
    if (fix_div)
      fixed = {(fix_sa ? -rem : rem), ((fix_sa ^ fix_sb) ? -quo : quo)};
    else if (fix_sa ^ fix_sb)
      fixed = -raw;
  end

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer between EX and the shared iterative mult/div engine, with
// engine-free special cases and a one-entry result cache.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int CACHE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              busy,
  output logic              eng_start,
  output logic              eng_mode,
  output logic [XLEN-1:0]   eng_a,
  output logic [XLEN-1:0]   eng_b,
  input  logic              eng_done,
  input  logic [2*XLEN-1:0] eng_result,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic              vld;
    md_class_e         cls;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2*XLEN-1:0] r;
  } cache_t;

  md_state_e         state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [TAG_W-1:0]  tag_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] r_q, r_fixed;
  cache_t            cache_q;

  logic              accept, sa_in, sb_in, sgn_div, b_zero, ovf, special, hit, cls_ok;
  logic [XLEN-1:0]   spec_res, mag_a, mag_b;

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign sgn_div = (req_op == MD_DIV) || (req_op == MD_REM);
  assign sa_in   = req_a[XLEN-1] && (sgn_div || req_op == MD_MULH || req_op == MD_MULHSU);
  assign sb_in   = req_b[XLEN-1] && (sgn_div || req_op == MD_MULH);

  // Divide-by-zero and INT_MIN/-1 resolve without the engine.
  assign b_zero   = (req_b == '0);
  assign ovf      = sgn_div && (req_a == INT_MIN) && (req_b == '1);
  assign special  = req_op[2] && (b_zero || ovf);
  assign spec_res = b_zero ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : INT_MIN);

  // Low product bits are sign-independent, so MUL may reuse any multiply entry.
  assign cls_ok = (req_op == MD_MUL) ? (cache_q.cls != CC_SDIV && cache_q.cls != CC_UDIV)
                                     : (cache_q.cls == op_class(req_op));
  assign hit    = (CACHE_EN != 0) && cache_q.vld && cls_ok &&
                  (cache_q.a == req_a) && (cache_q.b == req_b);

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .a       (req_a),
    .b       (req_b),
    .neg_a   (sa_in),
    .neg_b   (sb_in),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .fix_div (op_q[2]),
    .fix_sa  (sa_q),
    .fix_sb  (sb_q),
    .raw     (r_q),
    .fixed   (r_fixed)
  );

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (special || hit) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: begin
        // The pulse goes out even under flush so DRAIN always sees a done.
        eng_start = 1'b1;
        state_d   = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)         state_d = eng_done ? ST_IDLE : ST_DRAIN;
        else if (eng_done) state_d = ST_FIX;
      end
      ST_FIX:   state_d = flush ? ST_IDLE : ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_DRAIN: if (eng_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign resp_valid = (state_q == ST_RESP) && !flush;
  assign resp_data  = (state_q != ST_RESP) ? '0 :
                      op_takes_hi(op_q) ? r_q[2*XLEN-1:XLEN] : r_q[XLEN-1:0];
  assign resp_tag   = (state_q == ST_RESP) ? tag_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      r_q      <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      eng_mode <= 1'b0;
      cache_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        tag_q <= req_tag;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        if (special)
          r_q <= {spec_res, spec_res};
        else if (hit)
          r_q <= cache_q.r;
        else begin
          eng_a    <= mag_a;
          eng_b    <= mag_b;
          eng_mode <= req_op[2];
        end
      end
      if (state_q == ST_WAIT && eng_done && !flush)
        r_q <= eng_result;
      if (state_q == ST_FIX && !flush) begin
        r_q     <= r_fixed;
        cache_q <= '{vld: 1'b1, cls: op_class(op_q), a: a_q, b: b_q, r: r_fixed};
      end
    end
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
Sequencing controller between the EX stage and the shared 32-cycle iterative unsigned mult/div engine. It accepts one M-extension op at a time and converts signed operands to magnitudes. It issues the engine and waits on its done handshake, then applies sign correction. Div-by-zero and signed overflow are resolved without the engine, and a one-entry result cache serves DIV/REM and MUL/MULH pairs on identical operands in one cycle.

Parameters:
XLEN, 32, datapath width
TAG_W, 5, destination tag width (rd index)
CACHE_EN, 1, 1 enables the one-entry result cache; 0 makes every op a miss

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  EX presents an M op
req_ready  out  1  high only in IDLE with flush low; accept = req_valid & req_ready
req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  XLEN  rs1 value
req_b  in  XLEN  rs2 value
req_tag  in  TAG_W  destination tag
flush  in  1  kill the in-flight op
busy  out  1  pipeline stall; high in every state except IDLE
eng_start  out  1  one-cycle pulse that starts the engine
eng_mode  out  1  0 multiply, 1 divide
eng_a  out  XLEN  magnitude of operand A; held stable from ISSUE through done
eng_b  out  XLEN  magnitude of operand B; held stable from ISSUE through done
eng_done  in  1  one-cycle pulse; eng_result valid in the same cycle
eng_result  in  2*XLEN  multiply: {hi,lo} product; divide: {remainder,quotient}
resp_valid  out  1  one-cycle result pulse
resp_data  out  XLEN  result
resp_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state IDLE, cache invalidated.
  - resp_valid, eng_start, busy, resp_data, resp_tag, eng_a, eng_b, eng_mode all 0.
  - The engine shares rst, so a reset mid-op abandons everything with no response.
- States: IDLE, ISSUE, WAIT, FIX, RESP, DRAIN.
- IDLE, on accept, latch op, a, b, tag, sa, sb:
  - sa = a[XLEN-1] for MULH, MULHSU, DIV, REM; otherwise 0.
  - sb = b[XLEN-1] for MULH, DIV, REM; otherwise 0.
  - Next state is RESP when the op is a special case or a cache hit; otherwise ISSUE.
- Special cases (next state RESP):
  - DIV/DIVU with b=0: result all ones.
  - REM/REMU with b=0: result = a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Cache hit: CACHE_EN, entry valid, equal a and b, and one of:
  - DIV/REM hits a signed-divide entry; DIVU/REMU hits an unsigned-divide entry.
  - MUL hits any multiply entry.
  - MULH/MULHSU/MULHU hit only an entry of the same variant.
- ISSUE:
  - eng_start=1 for exactly one cycle.
  - eng_a = sa ? -a : a; eng_b = sb ? -b : b; eng_mode = op>=4.
  - Next state WAIT.
- WAIT: hold until eng_done. Capture eng_result, then go to FIX.
- FIX, 64-bit corrected result R:
  - Multiply: R = product, negated as a full 64-bit two's complement if sa^sb.
  - Divide: quotient negated if sa^sb; remainder negated if sa.
  - Write the cache entry (a, b, class, R); next state RESP.
- RESP:
  - resp_valid=1 with resp_tag.
  - resp_data = lo of R for MUL/DIV/DIVU; hi of R for MULH/MULHSU/MULHU/REM/REMU.
  - Next state IDLE.
  - No back-pressure: a new accept is possible on the following cycle.
- Latency, accept cycle to resp_valid:
  - Engine path: 1 (ISSUE) + engine latency + 1 (FIX) + 1 (RESP).
  - Special case or cache hit: exactly 1 cycle.
- Flush:
  - In ISSUE or WAIT: go to DRAIN; no response and no cache write.
  - flush coincident with eng_done in WAIT: result discarded, go directly to IDLE.
  - In FIX or RESP: go to IDLE, resp_valid forced 0, no cache write.
  - In IDLE: no accept that cycle.
- DRAIN: wait for eng_done, discard the result, then go to IDLE. req_ready stays low throughout.
- rst has priority over flush, and flush over everything else.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MUL..MD_REMU;
  - state encodings;
  - cache class codes (SDIV, UDIV, MULH, MULHSU, MULHU).
- One natural sub-module: muldiv_signfix, a combinational operand-magnitude and 64-bit result-correction unit.

Test Plan:
- MULH a=0xFFFFFFFE, b=3, engine latency 32 -> one eng_start; resp_data=0xFFFFFFFF 35 cycles after accept.
- DIV a=-7, b=2, then REM same operands -> DIV resp 0xFFFFFFFD via engine; REM resp 0xFFFFFFFF one cycle after accept, no eng_start.
- DIVU a=5, b=0 -> resp 0xFFFFFFFF after 1 cycle; REM a=0x80000000, b=0xFFFFFFFF -> resp 0, no eng_start.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> resp 0xFFFFFFFF; then MULHU same operands -> cache miss, engine issued, resp 0xFFFFFFFE.
- flush at cycle 10 of WAIT -> busy high until eng_done, no resp_valid; next MUL 3*4 -> resp 12.
- rst asserted in WAIT -> next cycle busy=0, resp_valid=0; repeat the previous DIV operands -> engine reissued (cache cleared).
